// File: rtl/wm8731_config_sequencer_if.sv
// Control-port bundle between the WM8731 sequencer, the I2C controller and the host.
// Handshakes: req stays high with wdata stable until a one-cycle ack; host_req stays
// high with host_reg/host_data stable until a one-cycle host_ack.
interface wm8731_config_sequencer_if;
   logic            req;
   logic [6:0]      addr;
   logic [1:0][7:0] wdata;
   logic            ack;
   logic            host_req;
   logic [6:0]      host_reg;
   logic [8:0]      host_data;
   logic            host_ack;

   modport master (output req, addr, wdata, host_ack,
                   input  ack, host_req, host_reg, host_data);
   modport slave  (input  req, addr, wdata, host_ack,
                   output ack, host_req, host_reg, host_data);
endinterface

// File: rtl/wm8731_config_sequencer.sv
// Writes the WM8731 power-up register table over I2C, then serves single host writes,
// supervising every transfer with a timeout.
module wm8731_config_sequencer #(
   parameter logic [6:0] DEV_ADDR       = 7'h1A,
   parameter int         PWRUP_CYCLES   = 240000,
   parameter int         GAP_CYCLES     = 2400,
   parameter int         TIMEOUT_CYCLES = 2400000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   wm8731_config_sequencer_if.master  bus,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [3:0]                 err_index,
   output logic [2:0]                 dbg_state
);

   localparam int CW = $clog2((PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] PWR_LAST = CW'(PWRUP_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      PWRUP, ISSUE, WAIT_ACK, GAP, DONE, HOST_WAIT
   } state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [TW-1:0]   tcnt, tcnt_n;
   logic [3:0]      idx, idx_n;
   logic            req_q, req_n;
   logic [15:0]     wdata_q, wdata_n;
   logic            host_ack_q, host_ack_n;
   logic            error_n;
   logic [3:0]      err_index_n;
   logic            pend, pend_n;
   logic            restart, go_pwrup, timed_out, xfer_end;

   // Index 10 is the activate write, deliberately last so the codec only runs once configured.
   function automatic logic [15:0] table_word(input logic [3:0] i);
      logic [15:0] w;
      case (i)
         4'd0:    w = {7'd15, 9'h000};
         4'd1:    w = {7'd0,  9'h017};
         4'd2:    w = {7'd1,  9'h017};
         4'd3:    w = {7'd2,  9'h079};
         4'd4:    w = {7'd3,  9'h079};
         4'd5:    w = {7'd4,  9'h012};
         4'd6:    w = {7'd5,  9'h000};
         4'd7:    w = {7'd6,  9'h000};
         4'd8:    w = {7'd7,  9'h002};
         4'd9:    w = {7'd8,  9'h000};
         default: w = {7'd9,  9'h001};
      endcase
      return w;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= PWRUP;
         cnt        <= '0;
         tcnt       <= '0;
         idx        <= '0;
         req_q      <= 1'b0;
         wdata_q    <= '0;
         host_ack_q <= 1'b0;
         error      <= 1'b0;
         err_index  <= '0;
         pend       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         tcnt       <= tcnt_n;
         idx        <= idx_n;
         req_q      <= req_n;
         wdata_q    <= wdata_n;
         host_ack_q <= host_ack_n;
         error      <= error_n;
         err_index  <= err_index_n;
         pend       <= pend_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      tcnt_n      = tcnt;
      idx_n       = idx;
      req_n       = req_q;
      wdata_n     = wdata_q;
      host_ack_n  = 1'b0;
      error_n     = error;
      err_index_n = err_index;
      pend_n      = pend;
      go_pwrup    = 1'b0;
      timed_out   = 1'b0;
      restart     = start | pend;
      // ack beats a coincident timeout, so a late-but-valid ack never records an error.
      xfer_end    = bus.ack | (tcnt == TO_LAST);
      case (state)
         PWRUP: begin
            if (start) go_pwrup = 1'b1;
            else if (cnt == PWR_LAST) begin
               state_n = ISSUE;
               idx_n   = '0;
               cnt_n   = '0;
            end else cnt_n = cnt + CW'(1);
         end
         ISSUE: begin
            wdata_n = table_word(idx);
            req_n   = 1'b1;
            tcnt_n  = '0;
            state_n = WAIT_ACK;
            pend_n  = pend | start;
         end
         WAIT_ACK: begin
            if (xfer_end) begin
               req_n     = 1'b0;
               timed_out = ~bus.ack;
               if (restart) go_pwrup = 1'b1;
               else if (idx == 4'd10) state_n = DONE;
               else begin
                  idx_n   = idx + 4'd1;
                  cnt_n   = '0;
                  state_n = GAP;
               end
            end else begin
               tcnt_n = tcnt + TW'(1);
               pend_n = pend | start;
            end
         end
         GAP: begin
            if (restart) go_pwrup = 1'b1;
            else if (cnt == GAP_LAST) begin
               state_n = ISSUE;
               cnt_n   = '0;
            end else cnt_n = cnt + CW'(1);
         end
         DONE: begin
            if (start) go_pwrup = 1'b1;
            else if (bus.host_req) begin
               wdata_n = {bus.host_reg, bus.host_data};
               req_n   = 1'b1;
               tcnt_n  = '0;
               state_n = HOST_WAIT;
            end
         end
         HOST_WAIT: begin
            if (xfer_end) begin
               req_n      = 1'b0;
               host_ack_n = 1'b1;
               timed_out  = ~bus.ack;
               if (restart) go_pwrup = 1'b1;
               else state_n = DONE;
            end else begin
               tcnt_n = tcnt + TW'(1);
               pend_n = pend | start;
            end
         end
         default: state_n = PWRUP;
      endcase
      if (go_pwrup) begin
         state_n     = PWRUP;
         cnt_n       = '0;
         pend_n      = 1'b0;
         error_n     = 1'b0;
         err_index_n = '0;
      end
      // A timeout on the very transfer that takes a restart is still reported.
      if (timed_out) begin
         error_n     = 1'b1;
         err_index_n = (state == HOST_WAIT) ? 4'hF : idx;
      end
   end

   assign bus.req      = req_q;
   assign bus.addr     = DEV_ADDR;
   assign bus.wdata    = wdata_q;
   assign bus.host_ack = host_ack_q;
   assign busy         = (state != DONE);
   assign done         = (state == DONE);
   assign dbg_state    = state;

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Directed bench for wm8731_config_sequencer with a small I2C responder that acks
// a fixed number of cycles after each req rise, with per-word overrides.
module tb_wm8731_config_sequencer;

   localparam int ACK_DELAY = 50;
   localparam logic [15:0] NONE = 16'hFFFF;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, error;
   logic [3:0] err_index;
   logic [2:0] dbg_state;

   wm8731_config_sequencer_if bus ();

   wm8731_config_sequencer #(
      .DEV_ADDR(7'h1A), .PWRUP_CYCLES(10), .GAP_CYCLES(4), .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .busy(busy), .done(done), .error(error), .err_index(err_index), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   int          len_q[$];
   int          host_ack_cnt = 0;
   int          stable_err = 0;
   int          age = 0;
   logic        req_prev = 1'b0;
   logic [15:0] cur_word = '0;
   logic [15:0] no_ack_word = NONE;
   logic [15:0] late_word = NONE;
   int          late_delay = 0;

   // Responder and monitor: runs on the falling edge so ack lands cleanly at the next rise.
   always @(negedge clk) begin
      if (bus.req) begin
         age = age + 1;
         if (!req_prev) begin
            got_q.push_back(bus.wdata);
            cur_word = bus.wdata;
         end else if (bus.wdata !== cur_word) stable_err = stable_err + 1;
         bus.ack = (cur_word != no_ack_word) &&
                   (age == ((cur_word == late_word) ? late_delay : ACK_DELAY));
      end else begin
         if (req_prev) len_q.push_back(age);
         age = 0;
         bus.ack = 1'b0;
      end
      if (bus.host_ack === 1'b1) host_ack_cnt = host_ack_cnt + 1;
      req_prev = bus.req;
   end

   task automatic apply_reset();
      reset = 1'b1;
      start = 1'b0;
      bus.host_req = 1'b0;
      repeat (3) @(negedge clk);
      got_q.delete();
      len_q.delete();
      host_ack_cnt = 0;
      stable_err = 0;
      reset = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         $display("FAIL %s_done: done=%b after %0d cycles, required 1", tag, done, budget);
         failures++;
      end
   endtask

   task automatic wait_word(input logic [15:0] w, input int budget, input string tag);
      int n = 0;
      while (!(bus.req === 1'b1 && bus.wdata === w) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!(bus.req === 1'b1 && bus.wdata === w)) begin
         $display("FAIL %s_wait: word %h not issued within %0d cycles, required it", tag, w, budget);
         failures++;
      end
   endtask

   task automatic load_table();
      exp_q.push_back(16'h1E00); exp_q.push_back(16'h0017); exp_q.push_back(16'h0217);
      exp_q.push_back(16'h0479); exp_q.push_back(16'h0679); exp_q.push_back(16'h0812);
      exp_q.push_back(16'h0A00); exp_q.push_back(16'h0C00); exp_q.push_back(16'h0E02);
      exp_q.push_back(16'h1000); exp_q.push_back(16'h1201);
   endtask

   task automatic check_words(input string tag);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         $display("FAIL %s_count: writes=%0d, required %0d", tag, got_q.size(), exp_q.size());
         failures++;
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            $display("FAIL %s_word[%0d]: got %h, required %h", tag, i, got_q[i], exp_q[i]);
            failures++;
         end
      end
      checks++;
      if (stable_err != 0) begin
         $display("FAIL %s_stable: wdata changed %0d times under req, required 0", tag, stable_err);
         failures++;
      end
   endtask

   task automatic check_outputs_reset(input string tag);
      checks++;
      if ({bus.req, bus.wdata, bus.host_ack, busy, done, error, err_index} !==
          {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0}) begin
         $display("FAIL %s: req=%b wdata=%h host_ack=%b busy=%b done=%b error=%b err_index=%h, required 0 0000 0 1 0 0 0",
                  tag, bus.req, bus.wdata, bus.host_ack, busy, done, error, err_index);
         failures++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      reset = 1'b1;
      @(negedge clk);
      check_outputs_reset("reset_values");
      checks++;
      if (bus.addr !== 7'h1A) begin
         $display("FAIL reset_addr: addr=%h, required 1a", bus.addr);
         failures++;
      end
   endtask

   task automatic test_table();
      apply_reset();
      wait_done(2000, "table");
      repeat (5) @(negedge clk);
      exp_q.delete();
      load_table();
      check_words("table");
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL table_status: error=%b busy=%b, required 0 0", error, busy);
         failures++;
      end
      checks++;
      if (len_q.size() != 11 || len_q[0] != ACK_DELAY) begin
         $display("FAIL table_len: transfers=%0d, required 11 of %0d cycles", len_q.size(), ACK_DELAY);
         failures++;
      end
   endtask

   task automatic test_timeout();
      no_ack_word = 16'h0479;
      apply_reset();
      wait_done(4000, "timeout");
      no_ack_word = NONE;
      exp_q.delete();
      load_table();
      check_words("timeout");
      checks++;
      if (error !== 1'b1 || err_index !== 4'd3) begin
         $display("FAIL timeout_err: error=%b err_index=%0d, required 1 3", error, err_index);
         failures++;
      end
      checks++;
      if (len_q.size() < 4 || len_q[3] != 1000) begin
         $display("FAIL timeout_len: req high %0d cycles for index 3, required 1000",
                  (len_q.size() >= 4) ? len_q[3] : -1);
         failures++;
      end
   endtask

   task automatic test_ack_at_timeout();
      late_word = 16'h0812;
      late_delay = 1000;
      apply_reset();
      wait_done(4000, "ack_edge");
      late_word = NONE;
      checks++;
      if (error !== 1'b0 || err_index !== 4'd0 || got_q.size() != 11) begin
         $display("FAIL ack_edge_status: error=%b err_index=%0d writes=%0d, required 0 0 11",
                  error, err_index, got_q.size());
         failures++;
      end
      checks++;
      if (len_q.size() < 6 || len_q[5] != 1000) begin
         $display("FAIL ack_edge_len: index 5 held %0d cycles, required 1000",
                  (len_q.size() >= 6) ? len_q[5] : -1);
         failures++;
      end
   endtask

   task automatic test_host_write();
      int n = 0;
      apply_reset();
      bus.host_reg = 7'h02;
      bus.host_data = 9'h07F;
      bus.host_req = 1'b1;
      wait_done(2000, "host");
      checks++;
      if (host_ack_cnt != 0) begin
         $display("FAIL host_early: host_ack pulses before done=%0d, required 0", host_ack_cnt);
         failures++;
      end
      while (bus.host_ack !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      bus.host_req = 1'b0;
      checks++;
      if (bus.host_ack !== 1'b1 || bus.req !== 1'b0) begin
         $display("FAIL host_ack_edge: host_ack=%b req=%b, required 1 0", bus.host_ack, bus.req);
         failures++;
      end
      repeat (20) @(negedge clk);
      exp_q.delete();
      load_table();
      exp_q.push_back(16'h047F);
      check_words("host");
      checks++;
      if (host_ack_cnt != 1 || done !== 1'b1 || error !== 1'b0) begin
         $display("FAIL host_final: host_acks=%0d done=%b error=%b, required 1 1 0",
                  host_ack_cnt, done, error);
         failures++;
      end
   endtask

   task automatic test_start_mid();
      no_ack_word = 16'h0479;
      apply_reset();
      wait_word(16'h0A00, 3000, "restart");
      checks++;
      if (error !== 1'b1 || err_index !== 4'd3) begin
         $display("FAIL restart_pre_err: error=%b err_index=%0d, required 1 3", error, err_index);
         failures++;
      end
      no_ack_word = NONE;
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3000, "restart");
      exp_q.delete();
      load_table();
      for (int i = 7; i < 11; i++) void'(exp_q.pop_back());
      load_table();
      check_words("restart");
      checks++;
      if (len_q.size() < 7 || len_q[6] != ACK_DELAY) begin
         $display("FAIL restart_inflight: index 6 held %0d cycles, required %0d",
                  (len_q.size() >= 7) ? len_q[6] : -1, ACK_DELAY);
         failures++;
      end
      checks++;
      if (error !== 1'b0 || err_index !== 4'd0) begin
         $display("FAIL restart_err: error=%b err_index=%0d, required 0 0", error, err_index);
         failures++;
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      wait_word(16'h0479, 2000, "reset_mid");
      repeat (5) @(negedge clk);
      #1 reset = 1'b1;
      #1 check_outputs_reset("reset_mid_values");
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      bus.host_req = 1'b0;
      bus.host_reg = '0;
      bus.host_data = '0;
      test_reset();
      test_table();
      test_timeout();
      test_ack_at_timeout();
      test_host_write();
      test_start_mid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
